// File: rtl/cotm32_trap_ctrl.sv
// cotm32 machine-mode trap controller: M-mode trap CSRs, Zicsr access, trap/MRET sequencing.
// Optional build macro COTM32_MTVEC_VECTORED_EN enables vectored mtvec mode.
module cotm32_trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
   parameter int unsigned IRQ_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        exc_valid,
   input  logic [31:0] exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic        boundary,
   input  logic [31:0] boundary_pc,
   input  logic        irq_msi,
   input  logic        irq_mti,
   input  logic        irq_mei,
   output logic        flush_req,
   input  logic        flush_ack,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic [1:0]  priv,
   output logic        busy
);

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
   state_t state;

   logic [IRQ_SYNC_STAGES-1:0] msi_sync, mti_sync, mei_sync;
   logic [2:0]  mip_bits, mie_en, pend;
   logic        st_mie, st_mpie;
   logic [1:0]  st_mpp;
   logic [29:0] mtvec_base;
   logic        mtvec_mode;
   logic [31:0] mscratch, mepc_r, mcause, mtval;

   logic        csr_hit, csr_we;
   logic [31:0] csr_val, csr_new;
   logic        idle, gie, irq_any;
   logic        take_exc, take_mret, take_irq, mret_ok, trap_entry, accept;
   logic [3:0]  irq_code;
   logic [29:0] vec_off;
   logic [31:0] trap_cause, trap_epc, trap_tval, next_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msi_sync <= '0;
         mti_sync <= '0;
         mei_sync <= '0;
      end else begin
         msi_sync <= {msi_sync[IRQ_SYNC_STAGES-2:0], irq_msi};
         mti_sync <= {mti_sync[IRQ_SYNC_STAGES-2:0], irq_mti};
         mei_sync <= {mei_sync[IRQ_SYNC_STAGES-2:0], irq_mei};
      end
   end

   // bit order {MEI, MTI, MSI} matches mip/mie bits 11/7/3
   assign mip_bits = {mei_sync[IRQ_SYNC_STAGES-1], mti_sync[IRQ_SYNC_STAGES-1],
                      msi_sync[IRQ_SYNC_STAGES-1]};

   always_comb begin
      csr_hit = 1'b1;
      csr_val = '0;
      case (csr_addr)
         12'h300: csr_val = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
         12'h304: csr_val = {20'b0, mie_en[2], 3'b0, mie_en[1], 3'b0, mie_en[0], 3'b0};
         12'h305: csr_val = {mtvec_base, 1'b0, mtvec_mode};
         12'h340: csr_val = mscratch;
         12'h341: csr_val = mepc_r;
         12'h342: csr_val = mcause;
         12'h343: csr_val = mtval;
         12'h344: csr_val = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
         default: csr_hit = 1'b0;
      endcase
      case (csr_op)
         2'd1:    csr_new = csr_wdata;
         2'd2:    csr_new = csr_val | csr_wdata;
         2'd3:    csr_new = csr_val & ~csr_wdata;
         default: csr_new = csr_val;
      endcase
   end

   assign csr_illegal = (csr_op != 2'd0) && (!csr_hit || priv == PRIV_U);
   assign csr_rdata   = (csr_hit && priv != PRIV_U) ? csr_val : '0;
   assign idle        = (state == IDLE);
   assign csr_we      = (csr_op != 2'd0) && !csr_illegal && idle;

   assign pend     = mip_bits & mie_en;
   assign gie      = (priv == PRIV_U) || st_mie;
   assign irq_any  = (|pend) && gie;
   assign irq_code = pend[2] ? 4'd11 : pend[0] ? 4'd3 : 4'd7;

   assign take_exc   = idle && exc_valid;
   assign take_mret  = idle && !exc_valid && mret_valid;
   assign take_irq   = idle && !exc_valid && !mret_valid && boundary && irq_any;
   assign mret_ok    = take_mret && (priv == PRIV_M);
   // MRET outside M becomes an illegal-instruction trap
   assign trap_entry = take_exc || (take_mret && priv != PRIV_M) || take_irq;
   assign accept     = trap_entry || mret_ok;

   assign trap_cause = take_irq ? {1'b1, 27'b0, irq_code} : take_exc ? exc_cause : 32'd2;
   assign trap_epc   = take_irq ? boundary_pc : exc_pc;
   assign trap_tval  = take_exc ? exc_tval : '0;
   assign vec_off    = (take_irq && mtvec_mode) ? {26'b0, irq_code} : '0;
   assign next_pc    = trap_entry ? {mtvec_base + vec_off, 2'b00} : mepc_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         priv       <= PRIV_M;
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         st_mpp     <= PRIV_U;
         mie_en     <= '0;
         mtvec_base <= RESET_MTVEC[31:2];
         mscratch   <= '0;
         mepc_r     <= '0;
         mcause     <= '0;
         mtval      <= '0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               12'h300: begin
                  st_mie  <= csr_new[3];
                  st_mpie <= csr_new[7];
                  st_mpp  <= (csr_new[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
               end
               12'h304: mie_en     <= {csr_new[11], csr_new[7], csr_new[3]};
               12'h305: mtvec_base <= csr_new[31:2];
               12'h340: mscratch   <= csr_new;
               12'h341: mepc_r     <= csr_new & 32'hFFFF_FFFC;
               12'h342: mcause     <= csr_new;
               12'h343: mtval      <= csr_new;
               default: ;
            endcase
         end
         // later assignments override a coincident CSR write on the same fields
         if (trap_entry) begin
            mepc_r  <= trap_epc & 32'hFFFF_FFFC;
            mcause  <= trap_cause;
            mtval   <= trap_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            st_mpp  <= priv;
            priv    <= PRIV_M;
         end else if (mret_ok) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
            priv    <= st_mpp;
            st_mpp  <= PRIV_U;
         end
      end
   end

`ifdef COTM32_MTVEC_VECTORED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mtvec_mode <= 1'b0;
      else if (csr_we && csr_addr == 12'h305)
         mtvec_mode <= (csr_new[1:0] == 2'b01);
   end
`else
   assign mtvec_mode = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_req      <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state       <= FLUSH;
               flush_req   <= 1'b1;
               busy        <= 1'b1;
               redirect_pc <= next_pc;
            end
            FLUSH: if (flush_ack) begin
               state          <= REDIRECT;
               flush_req      <= 1'b0;
               redirect_valid <= 1'b1;
            end
            REDIRECT: if (redirect_ready) begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cotm32_trap_ctrl.sv
// Directed self-checking bench for cotm32_trap_ctrl (honours COTM32_MTVEC_VECTORED_EN).
module tb_cotm32_trap_ctrl;

   localparam logic [31:0] RST_VEC = 32'h0000_1003;
   localparam logic [1:0]  OP_NONE = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;
`ifdef COTM32_MTVEC_VECTORED_EN
   localparam logic [31:0] EXP_MTVEC  = 32'h8000_0101;
   localparam logic [31:0] EXP_IRQ_PC = 32'h8000_012C;
`else
   localparam logic [31:0] EXP_MTVEC  = 32'h8000_0100;
   localparam logic [31:0] EXP_IRQ_PC = 32'h8000_0100;
`endif

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  csr_op = '0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0, csr_rdata;
   logic        csr_illegal;
   logic        exc_valid = 1'b0, mret_valid = 1'b0, boundary = 1'b0;
   logic [31:0] exc_cause = '0, exc_pc = '0, exc_tval = '0, boundary_pc = '0;
   logic        irq_msi = 1'b0, irq_mti = 1'b0, irq_mei = 1'b0;
   logic        flush_req, flush_ack = 1'b0, redirect_valid, redirect_ready = 1'b0;
   logic [31:0] redirect_pc;
   logic [1:0]  priv;
   logic        busy;

   int unsigned checks = 0, errors = 0;
   logic [31:0] r;
   logic        ill;

   cotm32_trap_ctrl #(.RESET_MTVEC(RST_VEC), .IRQ_SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .boundary(boundary), .boundary_pc(boundary_pc),
      .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
      .flush_req(flush_req), .flush_ack(flush_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .priv(priv), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic il);
      @(negedge clk);
      csr_op = op; csr_addr = addr; csr_wdata = wd;
      #1;
      rd = csr_rdata; il = csr_illegal;
      @(posedge clk); #1;
      csr_op = OP_NONE; csr_wdata = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      logic        i;
      csr(OP_RS, addr, 32'h0, v, i);
      check(tag, v, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] val);
      logic [31:0] v;
      logic        i;
      csr(OP_RW, addr, val, v, i);
   endtask

   task automatic fire(input logic e, input logic m, input logic b);
      @(negedge clk);
      exc_valid = e; mret_valid = m; boundary = b;
      @(posedge clk); #1;
      exc_valid = 1'b0; mret_valid = 1'b0; boundary = 1'b0;
   endtask

   // Entered just after the accept edge; both acks are raised together in FLUSH.
   task automatic handshake(input string tag, input logic [31:0] exp_pc, input int unsigned ack_delay);
      check({tag, "_flush"}, {31'b0, flush_req}, 32'd1);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      check({tag, "_rv_early"}, {31'b0, redirect_valid}, 32'd0);
      for (int unsigned i = 0; i < ack_delay; i++) begin
         @(posedge clk); #1;
         check({tag, "_flush_hold"}, {31'b0, flush_req}, 32'd1);
      end
      @(negedge clk); flush_ack = 1'b1; redirect_ready = 1'b1;
      @(posedge clk); #1; flush_ack = 1'b0; redirect_ready = 1'b0;
      check({tag, "_flush_drop"}, {31'b0, flush_req}, 32'd0);
      check({tag, "_rv"}, {31'b0, redirect_valid}, 32'd1);
      check({tag, "_pc"}, redirect_pc, exp_pc);
      @(posedge clk); #1;
      check({tag, "_rv_hold"}, {31'b0, redirect_valid}, 32'd1);
      check({tag, "_pc_hold"}, redirect_pc, exp_pc);
      @(negedge clk); redirect_ready = 1'b1;
      @(posedge clk); #1; redirect_ready = 1'b0;
      check({tag, "_rv_done"}, {31'b0, redirect_valid}, 32'd0);
      check({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #22;
      check("rst_priv", {30'b0, priv}, 32'd3);
      check("rst_flush", {31'b0, flush_req}, 32'd0);
      check("rst_rv", {31'b0, redirect_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_rpc", redirect_pc, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      rd_chk("rst_mstatus", 12'h300, 32'h0);
      rd_chk("rst_mtvec", 12'h305, 32'h0000_1000);
      wr(12'h305, 32'h8000_0101);
      rd_chk("mtvec_wr", 12'h305, EXP_MTVEC);

      csr(OP_RS, 12'h7C0, 32'h0, r, ill);
      check("unlisted_ill", {31'b0, ill}, 32'd1);
      check("unlisted_rd", r, 32'h0);
      csr(OP_RW, 12'h344, 32'hFFFF_FFFF, r, ill);
      check("mip_wr_ill", {31'b0, ill}, 32'd0);
      rd_chk("mip_ro", 12'h344, 32'h0);
      wr(12'h340, 32'hAAAA_5555);
      csr(OP_RC, 12'h340, 32'h0000_5555, r, ill);
      check("rc_old", r, 32'hAAAA_5555);
      csr(OP_RS, 12'h340, 32'h0000_0001, r, ill);
      check("rs_old", r, 32'hAAAA_0000);
      rd_chk("mscratch", 12'h340, 32'hAAAA_0001);

      exc_cause = 32'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
      fire(1'b1, 1'b0, 1'b0);
      handshake("exc", 32'h8000_0100, 2);
      rd_chk("exc_mepc", 12'h341, 32'h100);
      rd_chk("exc_mcause", 12'h342, 32'd2);
      rd_chk("exc_mtval", 12'h343, 32'hDEAD);
      rd_chk("exc_mstatus", 12'h300, 32'h0000_1800);

      wr(12'h300, 32'h0000_1000);
      rd_chk("mpp_warl", 12'h300, 32'h0);
      wr(12'h300, 32'h0000_0008);
      wr(12'h304, 32'hFFFF_FFFF);
      rd_chk("mie_mask", 12'h304, 32'h0000_0888);
      irq_mti = 1'b1; irq_mei = 1'b1;
      repeat (3) @(posedge clk);
      rd_chk("mip_sync", 12'h344, 32'h0000_0880);
      boundary_pc = 32'h200;
      fire(1'b0, 1'b0, 1'b1);
      handshake("irq", EXP_IRQ_PC, 0);
      irq_mti = 1'b0; irq_mei = 1'b0;
      rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
      rd_chk("irq_mepc", 12'h341, 32'h200);
      rd_chk("irq_mstatus", 12'h300, 32'h0000_1880);

      wr(12'h300, 32'h0000_0080);
      fire(1'b0, 1'b1, 1'b0);
      handshake("mret", 32'h200, 0);
      check("mret_priv", {30'b0, priv}, 32'd0);
      csr(OP_RS, 12'h300, 32'h0, r, ill);
      check("u_ill", {31'b0, ill}, 32'd1);
      check("u_rd", r, 32'h0);

      exc_pc = 32'h300; exc_tval = 32'h55;
      fire(1'b0, 1'b1, 1'b0);
      handshake("mret_u", 32'h8000_0100, 0);
      check("mret_u_priv", {30'b0, priv}, 32'd3);
      rd_chk("mret_u_mcause", 12'h342, 32'd2);
      rd_chk("mret_u_mepc", 12'h341, 32'h300);
      rd_chk("mret_u_mtval", 12'h343, 32'h0);
      rd_chk("mret_u_mstatus", 12'h300, 32'h0000_0080);

      exc_cause = 32'd5; exc_pc = 32'h400; exc_tval = 32'h77;
      fire(1'b1, 1'b1, 1'b0);
      wr(12'h340, 32'h0000_1234);
      handshake("both", 32'h8000_0100, 0);
      check("both_priv", {30'b0, priv}, 32'd3);
      rd_chk("both_mcause", 12'h342, 32'd5);
      rd_chk("busy_wr_drop", 12'h340, 32'hAAAA_0001);

      fire(1'b1, 1'b0, 1'b0);
      @(negedge clk); flush_ack = 1'b1;
      @(posedge clk); #1; flush_ack = 1'b0;
      check("pre_rst_rv", {31'b0, redirect_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rv", {31'b0, redirect_valid}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_rpc", redirect_pc, 32'h0);
      check("arst_priv", {30'b0, priv}, 32'd3);
      @(negedge clk); rst_n = 1'b1;
      rd_chk("arst_mstatus", 12'h300, 32'h0);
      rd_chk("arst_mie", 12'h304, 32'h0);
      rd_chk("arst_mtvec", 12'h305, 32'h0000_1000);
      rd_chk("arst_mscratch", 12'h340, 32'h0);
      rd_chk("arst_mepc", 12'h341, 32'h0);
      rd_chk("arst_mcause", 12'h342, 32'h0);
      rd_chk("arst_mtval", 12'h343, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
